// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with a per-register pending-producer
// scoreboard. Reads and busy flags are registered and see same-edge updates.

module regfile_sb_rd_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              busy_nxt,
  input  logic              wa_hit,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_hit,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  // Bypass order mirrors commit order: B lands last, so B wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (wb_hit && wb_addr == addr)      data <= wb_data;
      else if (wa_hit && wa_addr == addr) data <= wa_data;
      else                                data <= arr_data;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     busy_any
);
  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 is never written, so it reads as zero without special casing.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  busy = '0;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wa_hit, wb_hit, claim_hit;

  assign wa_hit    = wa_en    && (wa_addr    != '0);
  assign wb_hit    = wb_en    && (wb_addr    != '0);
  assign claim_hit = claim_en && (claim_addr != '0);

  // Writes retire the producer; a same-edge claim re-arms it.
  always_comb begin
    busy_nxt = busy;
    if (wa_hit)    busy_nxt[wa_addr]    = 1'b0;
    if (wb_hit)    busy_nxt[wb_addr]    = 1'b0;
    if (claim_hit) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wa_hit) mem[wa_addr] <= wa_data;
      if (wb_hit) mem[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_any <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_any <= |busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_sb_rd_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .addr     (a),
      .arr_data (mem[a]),
      .busy_nxt (busy_nxt[a]),
      .wa_hit   (wa_hit),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_hit   (wb_hit),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .data     (rd_data[k*DATA_W +: DATA_W]),
      .busy     (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized
// run over three parameterizations against an array-based reference model.

module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wa_en = 1'b0, wb_en = 1'b0, claim_en = 1'b0;
  logic [4:0]  wa_addr = '0, wb_addr = '0, claim_addr = '0;
  logic [31:0] wa_data = '0, wb_data = '0;
  logic [3:0][4:0] ra = '0;

  logic [1:0][31:0] d2;  logic [1:0] b2;  logic any2;
  logic [3:0][15:0] d4;  logic [3:0] b4;  logic any4;
  logic [15:0]      d1;  logic       b1;  logic any1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut2 (
    .clk(clk), .reset(reset), .rd_addr(ra[1:0]), .rd_data(d2), .rd_busy(b2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(any2));

  regfile_sb #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4)) dut4 (
    .clk(clk), .reset(reset), .rd_addr(ra), .rd_data(d4), .rd_busy(b4),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data[15:0]),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[15:0]),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(any4));

  regfile_sb #(.DATA_W(16), .ADDR_W(5), .NUM_RD(1)) dut1 (
    .clk(clk), .reset(reset), .rd_addr(ra[0]), .rd_data(d1), .rd_busy(b1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data[15:0]),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[15:0]),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(any1));

  // Architectural state after an edge: register 0 is immutable, B writes
  // after A, and a claim overrides any write-clear of the same register.
  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      if (wa_en && wa_addr != 0) begin m_mem[wa_addr] = wa_data; m_busy[wa_addr] = 1'b0; end
      if (wb_en && wb_addr != 0) begin m_mem[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0;
  endtask

  task automatic test_init_zero();
    ra[0] = 5'd5; ra[1] = 5'd31;
    cycle();
    checks++; if (d2[0] !== 32'h0) begin errors++; $display("FAIL init_zero r5: got %h want 0", d2[0]); end
    checks++; if (d2[1] !== 32'h0) begin errors++; $display("FAIL init_zero r31: got %h want 0", d2[1]); end
    checks++; if (any2 !== 1'b0) begin errors++; $display("FAIL init_zero busy_any: got %b want 0", any2); end
  endtask

  task automatic test_reset();
    reset = 1'b1; ra[0] = 5'd1; ra[1] = 5'd2;
    cycle();
    checks++; if (d2 !== '0) begin errors++; $display("FAIL reset rd_data: got %h want 0", d2); end
    checks++; if (b2 !== 2'b00) begin errors++; $display("FAIL reset rd_busy: got %b want 00", b2); end
    checks++; if (any2 !== 1'b0) begin errors++; $display("FAIL reset busy_any: got %b want 0", any2); end
    idle();
  endtask

  task automatic test_write_read();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF; ra[0] = 5'd0;
    cycle();
    idle(); ra[0] = 5'd5;
    cycle();
    checks++; if (d2[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read r5: got %h want deadbeef", d2[0]); end
  endtask

  task automatic test_ab_collision();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
    ra[1] = 5'd7;
    cycle();
    checks++; if (d2[1] !== 32'h22) begin errors++; $display("FAIL ab_bypass r7: got %h want 22", d2[1]); end
    idle();
    cycle();
    checks++; if (d2[1] !== 32'h22) begin errors++; $display("FAIL ab_stored r7: got %h want 22", d2[1]); end
  endtask

  task automatic test_r0();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_addr = 5'd0; ra[0] = 5'd0; ra[1] = 5'd0;
    cycle();
    idle();
    checks++; if (d2[0] !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h want 0", d2[0]); end
    cycle();
    checks++; if (d2[1] !== 32'h0) begin errors++; $display("FAIL r0_data: got %h want 0", d2[1]); end
    checks++; if (b2 !== 2'b00) begin errors++; $display("FAIL r0_busy: got %b want 00", b2); end
    checks++; if (any2 !== 1'b0) begin errors++; $display("FAIL r0_busy_any: got %b want 0", any2); end
  endtask

  task automatic test_scoreboard();
    claim_en = 1'b1; claim_addr = 5'd3; ra[0] = 5'd3; ra[1] = 5'd4;
    cycle();
    checks++; if (b2 !== 2'b01) begin errors++; $display("FAIL sb_claim rd_busy: got %b want 01", b2); end
    checks++; if (any2 !== 1'b1) begin errors++; $display("FAIL sb_claim busy_any: got %b want 1", any2); end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5;
    cycle();
    checks++; if (b2[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins rd_busy: got %b want 1", b2[0]); end
    checks++; if (d2[0] !== 32'hA5A5) begin errors++; $display("FAIL sb_set_wins data: got %h want a5a5", d2[0]); end
    claim_en = 1'b0; wb_data = 32'h5A5A;
    cycle();
    checks++; if (b2[0] !== 1'b0) begin errors++; $display("FAIL sb_clear rd_busy: got %b want 0", b2[0]); end
    checks++; if (any2 !== 1'b0) begin errors++; $display("FAIL sb_clear busy_any: got %b want 0", any2); end
    idle();
  endtask

  task automatic test_reset_priority();
    for (int i = 1; i < 32; i++) begin
      wa_en = 1'b1; wa_addr = 5'(i); wa_data = 32'(i);
      claim_en = 1'b1; claim_addr = 5'(i);
      cycle();
    end
    claim_en = 1'b0;
    reset = 1'b1; wa_addr = 5'd9; wa_data = 32'h55;
    claim_en = 1'b1; claim_addr = 5'd9;
    cycle();
    idle();
    checks++; if (any2 !== 1'b0) begin errors++; $display("FAIL rst_prio busy_any: got %b want 0", any2); end
    for (int i = 0; i < 16; i++) begin
      ra[0] = 5'(2*i); ra[1] = 5'(2*i+1);
      cycle();
      checks++; if (d2 !== '0) begin errors++; $display("FAIL rst_prio r%0d/r%0d: got %h want 0", 2*i, 2*i+1, d2); end
      checks++; if (b2 !== 2'b00 || any2 !== 1'b0) begin errors++; $display("FAIL rst_prio busy r%0d: got %b/%b want 00/0", 2*i, b2, any2); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      reset    = ($urandom_range(63) == 0);
      wa_en    = $urandom_range(1) == 1;
      wb_en    = $urandom_range(1) == 1;
      claim_en = $urandom_range(2) == 0;
      wa_addr    = 5'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
      wb_addr    = 5'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
      claim_addr = 5'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
      wa_data  = $urandom;
      wb_data  = $urandom;
      for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++; if (d2[k] !== m_mem[ra[k]]) begin errors++; $display("FAIL rnd dut2 data%0d r%0d: got %h want %h", k, ra[k], d2[k], m_mem[ra[k]]); end
        checks++; if (b2[k] !== m_busy[ra[k]]) begin errors++; $display("FAIL rnd dut2 busy%0d r%0d: got %b want %b", k, ra[k], b2[k], m_busy[ra[k]]); end
      end
      for (int k = 0; k < 4; k++) begin
        checks++; if (d4[k] !== m_mem[ra[k]][15:0]) begin errors++; $display("FAIL rnd dut4 data%0d r%0d: got %h want %h", k, ra[k], d4[k], m_mem[ra[k]][15:0]); end
        checks++; if (b4[k] !== m_busy[ra[k]]) begin errors++; $display("FAIL rnd dut4 busy%0d r%0d: got %b want %b", k, ra[k], b4[k], m_busy[ra[k]]); end
      end
      checks++; if (d1 !== m_mem[ra[0]][15:0]) begin errors++; $display("FAIL rnd dut1 data r%0d: got %h want %h", ra[0], d1, m_mem[ra[0]][15:0]); end
      checks++; if (b1 !== m_busy[ra[0]]) begin errors++; $display("FAIL rnd dut1 busy r%0d: got %b want %b", ra[0], b1, m_busy[ra[0]]); end
      checks++;
      if (any2 !== (|m_busy) || any4 !== (|m_busy) || any1 !== (|m_busy)) begin
        errors++; $display("FAIL rnd busy_any: got %b%b%b want %b", any2, any4, any1, |m_busy);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
    @(negedge clk);
    test_init_zero();
    test_reset();
    test_write_read();
    test_ab_collision();
    test_r0();
    test_scoreboard();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, 32, register data width in bits.
REQ-002 Parameter ADDR_W, 5, address width; depth = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2, number of independent read ports (1..4).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rd_addr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 rd_data  output  NUM_RD*DATA_W  registered read data, port k at bits [k*DATA_W +: DATA_W].
REQ-008 rd_busy  output  NUM_RD  registered scoreboard busy flag per read port.
REQ-009 wa_en, wa_addr, wa_data  input  1/ADDR_W/DATA_W  write port A.
REQ-010 wb_en, wb_addr, wb_data  input  1/ADDR_W/DATA_W  write port B.
REQ-011 claim_en, claim_addr  input  1/ADDR_W  marks a register as having a pending producer.
REQ-012 busy_any  output  1  registered OR of all scoreboard bits.

Function
REQ-013 Register 0 SHALL always read as zero; writes and claims to address 0 are ignored; its busy bit is constantly 0.
REQ-014 Writes SHALL commit on the rising edge of clk when the port's enable is high and address is nonzero.
REQ-015 Same-cycle writes from A and B to the same address: port B data SHALL be stored; A is dropped.
REQ-016 Read latency SHALL be exactly one cycle: rd_data[k] in cycle n+1 reflects rd_addr[k] sampled at edge n.
REQ-017 Write-through bypass: if rd_addr[k] matches an enabled nonzero write address in the same cycle, rd_data[k] SHALL return that write data (B over A), not the stale array value.
REQ-018 Scoreboard: one busy bit per register; claim_en SHALL set busy[claim_addr] at the next edge.
REQ-019 An enabled write (A or B) SHALL clear busy[write address] at the next edge.
REQ-020 Simultaneous claim and write to the same address: set wins (new producer supersedes); data still written.
REQ-021 rd_busy[k] SHALL reflect busy state after the current edge's updates, i.e. same bypass semantics as data (claim-set and write-clear visible in the same registered output).
REQ-022 busy_any SHALL equal OR of the post-update busy vector, registered.
REQ-023 All read ports SHALL be independent; any number may address the same register.
REQ-024 No combinational path from any input to any output.

Reset
REQ-025 With reset high at a rising edge: all registers, busy bits, rd_data, rd_busy, busy_any SHALL be 0 after that edge.
REQ-026 Reset SHALL take priority over same-cycle writes and claims; they are discarded.
REQ-027 Array contents at time zero (before first reset) SHALL be zero in simulation.

Verification
REQ-028 Reset, then wa writes 0xDEADBEEF to r5, rd_addr0=5 next cycle -> rd_data0=0xDEADBEEF one cycle later.
REQ-029 wa r7=0x11, wb r7=0x22 same cycle, rd_addr1=7 same cycle -> rd_data1=0x22 next cycle (bypass, B priority), later reads 0x22.
REQ-030 wa to r0 with 0xFFFFFFFF, claim r0 -> rd_data for r0 stays 0, rd_busy 0, busy_any 0.
REQ-031 claim r3, read r3 -> rd_busy=1, busy_any=1; wb writes r3 while claim r3 again -> busy stays 1; next wb r3 without claim -> busy clears, busy_any=0.
REQ-032 Fill r1..r31 with index value, assert reset alongside wa r9=0x55 -> all reads return 0, busy_any=0.
REQ-033 Parameter sweep NUM_RD=1,4 and DATA_W=16: random writes/claims/reads checked against reference model every cycle.
